univ_shift_reg: RTL and testbench

- Parametrised successor to the team's single-bit storage elements: WIDTH-bit edge-triggered register with per-cycle enable and 8 operating modes (hold/load/shift/rotate/arith-shift/clear).
- Adds a burst engine: one start pulse runs a shift or rotate operation for a programmable number of consecutive cycles, with busy/done handshake.
- Used as a generic data-path staging/serialising element.

---
 rtl/univ_shift_reg.sv | 90 +++++++++
 tb/tb_univ_shift_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register with eight modes and a counted burst engine.
// A start pulse runs one shift/rotate op for nshift consecutive cycles with busy/done.
module univ_shift_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] nshift,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state;
   logic [2:0]       burst_op;
   logic [CNT_W-1:0] count;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] q_next;
   logic             launch;

   // Only the shifting/rotating modes (010..110) may start a burst.
   assign launch = (state == StIdle) && start && (nshift != '0) &&
                   (mode >= 3'd2) && (mode <= 3'd6);

   assign op_sel = (state == StRun) ? burst_op : mode;
   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

   always_comb begin
      q_next = q;
      unique case (op_sel)
         3'd0: q_next = q;
         3'd1: q_next = din;
         3'd2: q_next = {q[WIDTH-2:0], sin_l};
         3'd3: q_next = {sin_r, q[WIDTH-1:1]};
         3'd4: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         3'd5: q_next = {q[0], q[WIDTH-1:1]};
         3'd6: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         3'd7: q_next = '0;
         default: q_next = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         count    <= '0;
         burst_op <= 3'd0;
         state    <= StIdle;
      end else begin
         unique case (state)
            StIdle: begin
               done <= 1'b0;
               if (launch) begin
                  burst_op <= mode;
                  count    <= nshift;
                  busy     <= 1'b1;
                  state    <= StRun;
               end else if (en) begin
                  q <= q_next;
               end
            end
            StRun: begin
               q     <= q_next;
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_univ_shift_reg;

   logic       clk;
   logic       rst;
   logic       en;
   logic [2:0] mode;
   logic [7:0] din;
   logic       sin_l;
   logic       sin_r;
   logic       start;
   logic [3:0] nshift;
   logic [7:0] q;
   logic       sout_l;
   logic       sout_r;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .din    (din),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .start  (start),
      .nshift (nshift),
      .q      (q),
      .sout_l (sout_l),
      .sout_r (sout_r),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled and inputs changed 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      en = 1'b1; mode = 3'd1; din = v; start = 1'b0;
      tick();
      en = 1'b0;
      check("load", q, v);
   endtask

   logic [2:0] sm_mode [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [7:0] sm_exp  [6] = '{8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h00};
   logic [7:0] rl_exp  [3] = '{8'h03, 8'h06, 8'h0C};

   initial begin
      rst = 1'b1; en = 1'b0; mode = 3'd0; din = 8'h00;
      sin_l = 1'b0; sin_r = 1'b0; start = 1'b0; nshift = 4'd0;
      tick(); tick();
      check("rst_q", q, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b0;

      en = 1'b1; mode = 3'd1; din = 8'hA5;
      tick();
      check("load_a5", q, 8'hA5);
      en = 1'b0; din = 8'hFF;
      tick();
      check("en0_hold", q, 8'hA5);

      // Single-cycle modes from 0x96.
      sin_l = 1'b1; sin_r = 1'b0;
      for (int i = 0; i < 6; i++) begin
         load(8'h96);
         check("sout_l_96", sout_l, 1'b1);
         check("sout_r_96", sout_r, 1'b0);
         en = 1'b1; mode = sm_mode[i];
         tick();
         en = 1'b0;
         check($sformatf("mode%0d", sm_mode[i]), q, sm_exp[i]);
         check("sout_l", sout_l, sm_exp[i][7]);
         check("sout_r", sout_r, sm_exp[i][0]);
      end

      // Burst rotl x3 with en and mode wiggled during RUN.
      load(8'h81);
      start = 1'b1; mode = 3'd4; nshift = 4'd3;
      tick();
      start = 1'b0;
      check("rl_launch_q", q, 8'h81);
      check("rl_launch_busy", busy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         en = ~en; mode = 3'd7; din = 8'h55;
         tick();
         check("rl_q", q, rl_exp[i]);
         check("rl_busy", busy, (i < 2) ? 1'b1 : 1'b0);
         check("rl_done", done, (i == 2) ? 1'b1 : 1'b0);
      end
      en = 1'b0;
      tick();
      check("rl_done_drop", done, 1'b0);
      check("rl_idle_busy", busy, 1'b0);
      check("rl_hold_q", q, 8'h0C);

      // start during RUN is ignored.
      load(8'h01);
      start = 1'b1; mode = 3'd4; nshift = 4'd2;
      tick();
      mode = 3'd2; nshift = 4'd5;
      tick();
      start = 1'b0;
      check("sr_q1", q, 8'h02);
      tick();
      check("sr_q2", q, 8'h04);
      check("sr_done", done, 1'b1);
      check("sr_busy", busy, 1'b0);
      tick();
      check("sr_no_relaunch", busy, 1'b0);
      check("sr_done_drop", done, 1'b0);
      check("sr_q_hold", q, 8'h04);

      // nshift=0 start falls through to the en path.
      load(8'h0C);
      start = 1'b1; mode = 3'd2; nshift = 4'd0; en = 1'b1; sin_l = 1'b0;
      tick();
      check("n0_q", q, 8'h18);
      check("n0_busy", busy, 1'b0);
      check("n0_done", done, 1'b0);
      // start with load mode acts as a plain load.
      mode = 3'd1; nshift = 4'd3; din = 8'h5A;
      tick();
      start = 1'b0; en = 1'b0;
      check("ld_q", q, 8'h5A);
      check("ld_busy", busy, 1'b0);
      tick();
      check("ld_done", done, 1'b0);
      check("ld_hold", q, 8'h5A);

      // Reset mid-burst aborts without done.
      load(8'h0F);
      start = 1'b1; mode = 3'd5; nshift = 4'd15;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("rr_q4", q, 8'hF0);
      check("rr_busy4", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_q", q, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      tick();
      check("post_rst_done", done, 1'b0);
      check("post_rst_q", q, 8'h00);

      // Follow-up burst: shr x2 with sin_r=1.
      sin_r = 1'b1;
      start = 1'b1; mode = 3'd3; nshift = 4'd2;
      tick();
      start = 1'b0;
      tick();
      check("shr_q1", q, 8'h80);
      tick();
      check("shr_q2", q, 8'hC0);
      check("shr_done", done, 1'b1);

      // Long shl burst longer than WIDTH.
      en = 1'b1; mode = 3'd7;
      tick();
      en = 1'b0;
      check("clr", q, 8'h00);
      sin_l = 1'b1;
      start = 1'b1; mode = 3'd2; nshift = 4'd10;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         int unsigned k;
         k = (i > 8) ? 8 : i;
         tick();
         check("long_q", q, (32'd1 << k) - 32'd1);
         check("long_busy", busy, (i < 10) ? 1'b1 : 1'b0);
         check("long_done", done, (i == 10) ? 1'b1 : 1'b0);
      end
      tick();
      check("long_done_drop", done, 1'b0);
      check("long_q_hold", q, 8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
